// File: rtl/xnor_prbs_gen_chk.sv
// xnor_prbs_gen_chk: XNOR-feedback LFSR PRBS generator plus self-synchronising checker
// that seeds from the received stream, hunts for lock, and counts errors while locked.
module xnor_prbs_gen_chk #(
   parameter int WIDTH      = 7,
   parameter int TAP_A      = 7,
   parameter int TAP_B      = 6,
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_ERR = 8,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             gen_bit,
   output logic             gen_vld,
   input  logic             chk_bit,
   input  logic             chk_vld,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);
   localparam int CW = $clog2(WIDTH + LOCK_CNT + UNLOCK_ERR + 1);
   typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] g_q, g_d, c_q, c_d;
   logic             gen_bit_q, gen_bit_d, gen_vld_q;
   logic             fb, exp_bit, mis, cnt_err;
   logic [CW-1:0]    cnt_q, miss_q;
   logic             locked_q, err_pulse_q;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   always_comb begin
      fb        = ~(g_q[TAP_A-1] ^ g_q[TAP_B-1]);
      g_d       = en ? {g_q[WIDTH-2:0], fb} : g_q;
      gen_bit_d = en ? fb : gen_bit_q;
      exp_bit   = ~(c_q[TAP_A-1] ^ c_q[TAP_B-1]);
      mis       = chk_vld && (chk_bit != exp_bit);
      c_d       = chk_vld ? {c_q[WIDTH-2:0], chk_bit} : c_q;
      cnt_err   = mis && (state_q == LOCKED);
      // a clear coinciding with a counted error leaves that error counted
      err_cnt_d = clr_err ? ERR_W'(cnt_err) :
                  (cnt_err && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         g_q       <= '0;
         gen_bit_q <= 1'b0;
         gen_vld_q <= 1'b0;
         c_q       <= '0;
         err_cnt_q <= '0;
      end else begin
         g_q       <= g_d;
         gen_bit_q <= gen_bit_d;
         gen_vld_q <= en;
         c_q       <= c_d;
         err_cnt_q <= err_cnt_d;
      end
   end
   // cnt_q counts seed bits in SEED and consecutive matches in HUNT/LOCKED
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEED;
         cnt_q       <= '0;
         miss_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         err_pulse_q <= cnt_err;
         if (chk_vld) begin
            case (state_q)
               SEED: begin
                  if (cnt_q == CW'(WIDTH - 1)) begin
                     state_q <= HUNT;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               HUNT: begin
                  if (mis) begin
                     cnt_q <= '0;
                  end else if (cnt_q == CW'(LOCK_CNT - 1)) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                     cnt_q    <= '0;
                     miss_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               LOCKED: begin
                  if (mis && miss_q == CW'(UNLOCK_ERR - 1)) begin
                     state_q  <= SEED;
                     locked_q <= 1'b0;
                     cnt_q    <= '0;
                     miss_q   <= '0;
                  end else if (mis) begin
                     miss_q <= miss_q + 1'b1;
                     cnt_q  <= '0;
                  end else if (cnt_q == CW'(LOCK_CNT - 1)) begin
                     miss_q <= '0;
                     cnt_q  <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q  <= SEED;
                  locked_q <= 1'b0;
                  cnt_q    <= '0;
                  miss_q   <= '0;
               end
            endcase
         end
      end
   end
   assign gen_bit   = gen_bit_q;
   assign gen_vld   = gen_vld_q;
   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_xnor_prbs_gen_chk.sv
// tb_xnor_prbs_gen_chk: directed bench for the PRBS7 generator and checker,
// with a second ERR_W=4 instance for counter saturation and clear behaviour.
module tb_xnor_prbs_gen_chk;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr_err = 1'b0;
   logic lb = 1'b0, inv = 1'b0, flip = 1'b0, vld_drv = 1'b0, bit_drv = 1'b0;
   logic gen_bit, gen_vld, chk_bit, chk_vld, locked, err_pulse;
   logic [15:0] err_cnt;
   logic en2 = 1'b0, chk2_bit = 1'b0, chk2_vld = 1'b0, clr2 = 1'b0;
   logic gen2_bit, gen2_vld, locked2, err_pulse2;
   logic [3:0] err_cnt2;
   logic [7:0] exp8 = 8'b1111_1101;
   logic [6:0] m = '0;
   logic mb;
   int n_cmp = 0, n_bad = 0, pulses = 0;
   always #5 clk = ~clk;
   assign chk_vld = lb ? gen_vld : vld_drv;
   assign chk_bit = lb ? (gen_bit ^ inv ^ flip) : bit_drv;
   xnor_prbs_gen_chk dut (
      .clk(clk), .rst(rst), .en(en), .gen_bit(gen_bit), .gen_vld(gen_vld),
      .chk_bit(chk_bit), .chk_vld(chk_vld), .clr_err(clr_err),
      .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
   );
   xnor_prbs_gen_chk #(.ERR_W(4), .UNLOCK_ERR(64)) dut2 (
      .clk(clk), .rst(rst), .en(en2), .gen_bit(gen2_bit), .gen_vld(gen2_vld),
      .chk_bit(chk2_bit), .chk_vld(chk2_vld), .clr_err(clr2),
      .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic adv_model();
      mb = ~(m[6] ^ m[5]);
      m  = {m[5:0], mb};
   endtask
   initial begin
      step();
      step();
      chk("rst_gen_bit", 32'(gen_bit), 32'd0);
      chk("rst_gen_vld", 32'(gen_vld), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err_pulse", 32'(err_pulse), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         adv_model();
         chk("first8_bit", 32'(gen_bit), 32'(exp8[7-i]));
         chk("first8_vld", 32'(gen_vld), 32'd1);
      end
      en = 1'b0;
      step();
      chk("idle_vld", 32'(gen_vld), 32'd0);
      chk("idle_hold_bit", 32'(gen_bit), 32'd1);
      en = 1'b1;
      for (int i = 0; i < 254; i++) begin
         step();
         adv_model();
         chk("prbs_bit", 32'(gen_bit), 32'(mb));
         chk("no_lockup", 32'(dut.g_q == 7'h7F), 32'd0);
      end
      en  = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      lb  = 1'b1;
      en  = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         step();
         chk("lock_time", 32'(locked), 32'(n == 16));
      end
      for (int i = 0; i < 984; i++) begin
         step();
         pulses += int'(err_pulse);
      end
      chk("clean_pulses", 32'(pulses), 32'd0);
      chk("clean_err_cnt", 32'(err_cnt), 32'd0);
      chk("clean_locked", 32'(locked), 32'd1);
      flip = 1'b1;
      step();
      flip = 1'b0;
      for (int j = 0; j < 20; j++) begin
         chk("flip_pulse", 32'(err_pulse), 32'(j == 0 || j == 6 || j == 7));
         chk("flip_locked", 32'(locked), 32'd1);
         step();
      end
      chk("flip_err_cnt", 32'(err_cnt), 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      inv = 1'b1;
      for (int i = 0; i < 500; i++) begin
         step();
         chk("inv_unlocked", 32'(locked), 32'd0);
      end
      rst = 1'b1;
      inv = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("relock", 32'(locked), 32'd1);
      flip = 1'b1;
      step();
      flip = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("pre_rst_err_cnt", 32'(err_cnt), 32'd3);
      rst = 1'b1;
      step();
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
      chk("midrst_gen_vld", 32'(gen_vld), 32'd0);
      chk("midrst_gen_bit", 32'(gen_bit), 32'd0);
      step();
      rst = 1'b0;
      lb  = 1'b0;
      en  = 1'b0;
      chk2_bit = 1'b1;
      chk2_vld = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("ones_lock", 32'(locked2), 32'd1);
      chk("ones_err_cnt", 32'(err_cnt2), 32'd0);
      chk2_bit = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("zeros10_err_cnt", 32'(err_cnt2), 32'd9);
      chk2_vld = 1'b0;
      chk2_bit = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("gap_err_cnt", 32'(err_cnt2), 32'd9);
      chk("gap_pulse", 32'(err_pulse2), 32'd0);
      chk2_vld = 1'b1;
      chk2_bit = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("sat_err_cnt", 32'(err_cnt2), 32'd15);
      chk("sat_locked", 32'(locked2), 32'd1);
      clr2 = 1'b1;
      step();
      chk("clr_with_err", 32'(err_cnt2), 32'd1);
      chk("clr_with_err_pulse", 32'(err_pulse2), 32'd1);
      chk2_bit = 1'b1;
      step();
      chk("clr_no_err", 32'(err_cnt2), 32'd0);
      clr2 = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/xnor_prbs_gen_chk.md
# xnor_prbs_gen_chk

PRBS generator and self-synchronising checker built around an XNOR-feedback LFSR, giving the CMOS gate library a sequential consumer of the XNOR cell. The generator emits one pseudo-random bit per enabled cycle. The checker receives a serial bit stream, locks to it, and counts bit errors. Typical use is a loopback test of gate-level datapaths: gen_bit feeds the device under test, and its output returns on chk_bit.

## Interface
- WIDTH, 7: LFSR length. The default gives PRBS7, period 127.
- TAP_A, 7: first feedback tap, 1-based, must equal WIDTH.
- TAP_B, 6: second feedback tap, 1-based, 1 ≤ TAP_B < TAP_A.
- LOCK_CNT, 8: consecutive matches required to declare lock.
- UNLOCK_ERR, 8: mismatches that force loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset. Has priority over every other input.
- en  in  1  advance the generator by one bit.
- gen_bit  out  1  generated bit, registered.
- gen_vld  out  1  gen_bit is valid this cycle.
- chk_bit  in  1  received serial bit.
- chk_vld  in  1  chk_bit is valid this cycle.
- clr_err  in  1  synchronous clear of err_cnt.
- locked  out  1  checker is in the LOCKED state.
- err_pulse  out  1  one-cycle pulse per mismatch while LOCKED.
- err_cnt  out  ERR_W  saturating count of mismatches while LOCKED.

## Operation
- **Generator.**
  - State is g[WIDTH-1:0]; reset value is 0. The all-zeros state is legal with XNOR feedback.
  - Feedback: fb = ~(g[TAP_A-1] ^ g[TAP_B-1]).
  - On en: g <= {g[WIDTH-2:0], fb}, gen_bit <= fb, gen_vld <= 1.
  - Otherwise: g and gen_bit hold, gen_vld <= 0.
  - The all-ones state is the lock-up state. It is never reached from reset.
- **Checker shift register.**
  - c[WIDTH-1:0], reset value 0.
  - Every chk_vld cycle shifts in chk_bit: c <= {c[WIDTH-2:0], chk_bit}. This happens in every state.
  - Expected bit: exp = ~(c[TAP_A-1] ^ c[TAP_B-1]).
  - A mismatch is chk_vld & (chk_bit != exp).
- **Checker FSM.** Reset state is SEED. Counters are cleared on every state entry.
  - SEED: count chk_vld bits without comparing. After WIDTH bits, go to HUNT.
  - HUNT: compare each valid bit.
    - Match: increment run.
    - Mismatch: clear run.
    - When run reaches LOCK_CNT, go to LOCKED.
  - LOCKED: compare each valid bit.
    - Mismatch: err_pulse <= 1, err_cnt increments, miss increments.
    - LOCK_CNT consecutive matches clear miss.
    - When miss reaches UNLOCK_ERR, go to SEED.
- **Error counter.**
  - err_cnt saturates at 2^ERR_W-1.
  - clr_err zeroes err_cnt.
  - clr_err in the same cycle as a counted mismatch gives err_cnt = 1.
  - err_cnt is not cleared by loss of lock; only rst or clr_err clears it.
- **Error signature.** A single flipped bit produces exactly 3 mismatches: at the flip, and TAP_B and TAP_A valid bits later. The default UNLOCK_ERR therefore tolerates isolated errors.
- **Bit-inverted input.** An inverted PRBS input mismatches on every compared bit, so the checker never locks on it.
- **Constant-ones input.** A constant-1 input matches exp = 1 and will lock. This is a known property of the XNOR polynomial; integration must not idle the line high.

## Timing
- All outputs are registered. Reset values: gen_bit = 0, gen_vld = 0, locked = 0, err_pulse = 0, err_cnt = 0.
- Generator latency: en in cycle n gives gen_bit and gen_vld in cycle n+1.
- Checker latency: chk_bit in cycle n gives err_pulse, err_cnt and locked updates in cycle n+1.
- Lock time from reset with clean input: locked rises one cycle after the (WIDTH+LOCK_CNT)th valid bit. With the defaults this is the 15th valid bit.
- Gaps in chk_vld are allowed: all state and counters hold.
- rst asserted mid-operation returns every register to its reset value at the next edge, regardless of en, chk_vld or clr_err.

## Test plan
- Reset, then en = 1 for 8 cycles → gen_bit = 1,1,1,1,1,1,0,1, with gen_vld high for exactly 8 cycles.
- en = 1 for 254 cycles → the sequence repeats with period 127, and the internal state g is never 7'h7F.
- Loopback gen_bit → chk_bit, gen_vld → chk_vld → locked rises one cycle after the 15th valid bit; err_cnt = 0 after 1000 bits.
- Locked loopback, flip bit 200 → exactly 3 err_pulses, err_cnt = 3, locked stays 1.
- Inverted loopback → locked stays 0 for 500 bits. Then rst while locked on a clean stream → locked = 0 and err_cnt = 0 the next cycle.
- ERR_W = 4 with 20 forced errors → err_cnt saturates at 15. Then clr_err coincident with a mismatch → err_cnt = 1.
